// File: rtl/hazard_ctrl.sv
// Load-use stall / taken-branch flush controller that owns the ID/EX control pipeline register.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [1:0]       id_wb,
    input  logic [2:0]       id_m,
    input  logic [3:0]       id_ex,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             mem_branch_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             exmem_flush,
    output logic [1:0]       idex_wb,
    output logic [2:0]       idex_m,
    output logic [3:0]       idex_ex,
    output logic [REG_W-1:0] idex_rs,
    output logic [REG_W-1:0] idex_rt,
    output logic [REG_W-1:0] idex_dst,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       wb_q, wb_d;
    logic [2:0]       m_q, m_d;
    logic [3:0]       ex_q, ex_d;
    logic [REG_W-1:0] rs_q, rs_d;
    logic [REG_W-1:0] rt_q, rt_d;
    logic [REG_W-1:0] dst_q, dst_d;
    logic             uses_rt;
    logic             lu;

    // A load in EX whose destination feeds the ID instruction; r0 is never a real producer.
    always_comb begin
        uses_rt = id_ex[0] | id_m[2] | id_m[0];
        lu      = id_valid & m_q[1] & (dst_q != '0) &
                  ((dst_q == id_rs) | (uses_rt & (dst_q == id_rt)));
    end

    always_comb begin
        state_d = RUN;
        if (mem_branch_taken) begin
            state_d = FLUSH;
        end else if (lu) begin
            state_d = STALL;
        end
    end

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (mem_branch_taken) begin
            ifid_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (lu) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end
    end

    always_comb begin
        wb_d  = '0;
        m_d   = '0;
        ex_d  = '0;
        rs_d  = '0;
        rt_d  = '0;
        dst_d = '0;
        if (!mem_branch_taken && !lu && id_valid) begin
            wb_d  = id_wb;
            m_d   = id_m;
            ex_d  = id_ex;
            rs_d  = id_rs;
            rt_d  = id_rt;
            dst_d = id_ex[0] ? id_rd : id_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wb_q    <= '0;
            m_q     <= '0;
            ex_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
            m_q     <= m_d;
            ex_q    <= ex_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            dst_q   <= dst_d;
        end
    end

    assign state    = state_q;
    assign idex_wb  = wb_q;
    assign idex_m   = m_q;
    assign idex_ex  = ex_q;
    assign idex_rs  = rs_q;
    assign idex_rt  = rt_q;
    assign idex_dst = dst_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating: an all-ones count holds rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (mem_branch_taken && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (lu && !mem_branch_taken && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
